// File: rtl/morse_pkg.sv
// ============================================================================
// morse_pkg : shared code constants, FSM state and pattern types for the keyer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

   localparam logic [5:0] CODE_SPACE     = 6'd36;
   localparam logic [5:0] CODE_MAX_VALID = 6'd36;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_MARK  = 3'd2,
      ST_EGAP  = 3'd3,
      ST_CGAP  = 3'd4
   } state_t;

   // pat[0] is the first element sent; 1 = dash, 0 = dot
   typedef struct packed {
      logic [4:0] pat;
      logic [2:0] len;
   } pattern_t;

endpackage

`default_nettype wire

// File: rtl/morse_rom.sv
// ============================================================================
// morse_rom : combinational character code to element pattern lookup
// Revision  : 1.0
// ============================================================================
`default_nettype none

module morse_rom
   import morse_pkg::*;
(
   input  logic [5:0] code,
   output pattern_t   pattern
);

   always_comb begin
      pattern = '{5'b00000, 3'd0};
      case (code)
         6'd0 :  pattern = '{5'b00010, 3'd2};   // A .-
         6'd1 :  pattern = '{5'b00001, 3'd4};   // B -...
         6'd2 :  pattern = '{5'b00101, 3'd4};   // C -.-.
         6'd3 :  pattern = '{5'b00001, 3'd3};   // D -..
         6'd4 :  pattern = '{5'b00000, 3'd1};   // E .
         6'd5 :  pattern = '{5'b00100, 3'd4};   // F ..-.
         6'd6 :  pattern = '{5'b00011, 3'd3};   // G --.
         6'd7 :  pattern = '{5'b00000, 3'd4};   // H ....
         6'd8 :  pattern = '{5'b00000, 3'd2};   // I ..
         6'd9 :  pattern = '{5'b01110, 3'd4};   // J .---
         6'd10:  pattern = '{5'b00101, 3'd3};   // K -.-
         6'd11:  pattern = '{5'b00010, 3'd4};   // L .-..
         6'd12:  pattern = '{5'b00011, 3'd2};   // M --
         6'd13:  pattern = '{5'b00001, 3'd2};   // N -.
         6'd14:  pattern = '{5'b00111, 3'd3};   // O ---
         6'd15:  pattern = '{5'b00110, 3'd4};   // P .--.
         6'd16:  pattern = '{5'b01011, 3'd4};   // Q --.-
         6'd17:  pattern = '{5'b00010, 3'd3};   // R .-.
         6'd18:  pattern = '{5'b00000, 3'd3};   // S ...
         6'd19:  pattern = '{5'b00001, 3'd1};   // T -
         6'd20:  pattern = '{5'b00100, 3'd3};   // U ..-
         6'd21:  pattern = '{5'b01000, 3'd4};   // V ...-
         6'd22:  pattern = '{5'b00110, 3'd3};   // W .--
         6'd23:  pattern = '{5'b01001, 3'd4};   // X -..-
         6'd24:  pattern = '{5'b01101, 3'd4};   // Y -.--
         6'd25:  pattern = '{5'b00011, 3'd4};   // Z --..
         6'd26:  pattern = '{5'b11111, 3'd5};   // 0 -----
         6'd27:  pattern = '{5'b11110, 3'd5};   // 1 .----
         6'd28:  pattern = '{5'b11100, 3'd5};   // 2 ..---
         6'd29:  pattern = '{5'b11000, 3'd5};   // 3 ...--
         6'd30:  pattern = '{5'b10000, 3'd5};   // 4 ....-
         6'd31:  pattern = '{5'b00000, 3'd5};   // 5 .....
         6'd32:  pattern = '{5'b00001, 3'd5};   // 6 -....
         6'd33:  pattern = '{5'b00011, 3'd5};   // 7 --...
         6'd34:  pattern = '{5'b00111, 3'd5};   // 8 ---..
         6'd35:  pattern = '{5'b01111, 3'd5};   // 9 ----.
         default: pattern = '{5'b00000, 3'd0};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/morse_keyer.sv
// ============================================================================
// morse_keyer : serialises one Morse character at a time into a key waveform.
//               Define MORSE_INT_TICK_EN to derive the unit tick from clk/TICK_DIV.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module morse_keyer
   import morse_pkg::*;
#(
   parameter int DASH_UNITS = 3,
   parameter int CGAP_UNITS = 3,
   parameter int WGAP_UNITS = 4,
   parameter int TICK_DIV   = 5000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_in,
   input  logic       char_valid,
   input  logic [5:0] char_code,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       err_invalid
);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [4:0] elems, elems_nxt;
   logic [2:0] rem, rem_nxt;
   logic       key_nxt, err_nxt;
   logic       accept;
   logic       tick;
   pattern_t   rom_pat;

   morse_rom u_rom (
      .code    (char_code),
      .pattern (rom_pat)
   );

`ifdef MORSE_INT_TICK_EN
   localparam int DIV_W = $clog2(TICK_DIV);
   logic [DIV_W-1:0] div_cnt;
   logic             tick_in_unused;

   assign tick_in_unused = tick_in;
   assign tick           = (div_cnt == DIV_W'(TICK_DIV - 1));

   // Cleared on accept so the first unit of a character is always full length
   always_ff @(posedge clk) begin
      if (!reset_n || accept || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end
`else
   logic tick_div_unused;

   assign tick_div_unused = (TICK_DIV >= 2);
   assign tick            = tick_in;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         elems       <= '0;
         rem         <= '0;
         key_out     <= 1'b0;
         err_invalid <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         elems       <= elems_nxt;
         rem         <= rem_nxt;
         key_out     <= key_nxt;
         err_invalid <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      elems_nxt = elems;
      rem_nxt   = rem;
      key_nxt   = key_out;
      err_nxt   = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (char_valid) begin
               accept = 1'b1;
               if (char_code < CODE_SPACE) begin
                  elems_nxt = rom_pat.pat;
                  rem_nxt   = rom_pat.len;
                  state_nxt = ST_START;
               end else if (char_code == CODE_SPACE) begin
                  cnt_nxt   = 4'(WGAP_UNITS);
                  state_nxt = ST_CGAP;
               end else if (char_code > CODE_MAX_VALID) begin
                  err_nxt   = 1'b1;
               end
            end
         end
         ST_START: begin
            if (tick) begin
               key_nxt   = 1'b1;
               cnt_nxt   = elems[0] ? 4'(DASH_UNITS) : 4'd1;
               state_nxt = ST_MARK;
            end
         end
         ST_MARK: begin
            if (tick) begin
               if (cnt == 4'd1) begin
                  key_nxt = 1'b0;
                  // Shift now so elems[0] already names the next element in EGAP
                  if (rem > 3'd1) begin
                     cnt_nxt   = 4'd1;
                     elems_nxt = elems >> 1;
                     rem_nxt   = rem - 3'd1;
                     state_nxt = ST_EGAP;
                  end else begin
                     cnt_nxt   = 4'(CGAP_UNITS);
                     state_nxt = ST_CGAP;
                  end
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end
         ST_EGAP: begin
            if (tick) begin
               if (cnt == 4'd1) begin
                  key_nxt   = 1'b1;
                  cnt_nxt   = elems[0] ? 4'(DASH_UNITS) : 4'd1;
                  state_nxt = ST_MARK;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end
         ST_CGAP: begin
            if (tick) begin
               if (cnt == 4'd1)
                  state_nxt = ST_IDLE;
               else
                  cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      char_ready = (state == ST_IDLE);
      busy       = (state != ST_IDLE);
   end

endmodule

`default_nettype wire

// File: tb/tb_morse_keyer.sv
// ============================================================================
// tb_morse_keyer : directed self-checking bench for morse_keyer
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_morse_keyer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick_in = 1'b0;
   logic       char_valid = 1'b0;
   logic [5:0] char_code = '0;
   logic       char_ready;
   logic       key_out;
   logic       busy;
   logic       err_invalid;

   int n_checks = 0;
   int n_fail   = 0;
   int period   = 1;
   int phase    = 0;

   morse_keyer #(
      .DASH_UNITS (3),
      .CGAP_UNITS (3),
      .WGAP_UNITS (4),
      .TICK_DIV   (10)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick_in     (tick_in),
      .char_valid  (char_valid),
      .char_code   (char_code),
      .char_ready  (char_ready),
      .key_out     (key_out),
      .busy        (busy),
      .err_invalid (err_invalid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Advance one clock and leave the next tick value set up
   task automatic cycle();
      @(posedge clk);
      #1;
      if (period <= 1) begin
         tick_in = 1'b1;
      end else begin
         phase   = (phase + 1) % period;
         tick_in = (phase == period - 1);
      end
   endtask

   task automatic send(input logic [5:0] code);
      char_code  = code;
      char_valid = 1'b1;
      cycle();
      char_valid = 1'b0;
   endtask

   // k = 0 is the sample right after the accept edge
   task automatic measure(input int max_cyc, output int trace, output int rise,
                          output int high, output int fall, output int ready_at,
                          output int busy_cnt, output int err_cnt);
      logic prev;
      trace = 0; rise = -1; high = 0; fall = -1; ready_at = -1;
      busy_cnt = 0; err_cnt = 0; prev = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         if (k > 0) cycle();
         if (key_out) begin
            high++;
            if (rise < 0) rise = k;
            if (k < 32) trace[k] = 1'b1;
         end else if (prev) begin
            fall = k;
         end
         prev = key_out;
         if (busy) busy_cnt++;
         if (err_invalid) err_cnt++;
         if (char_ready) begin
            ready_at = k;
            break;
         end
      end
   endtask

   int trace, rise, high, fall, ready_at, busy_cnt, err_cnt;

   initial begin
      reset_n = 1'b0;
      period  = 1;
      cycle();
      cycle();
      check_eq("reset_key",   int'(key_out),     0);
      check_eq("reset_busy",  int'(busy),        0);
      check_eq("reset_ready", int'(char_ready),  1);
      check_eq("reset_err",   int'(err_invalid), 0);
      reset_n = 1'b1;
      cycle();

`ifdef MORSE_INT_TICK_EN
      // T: one dash of 3 units, unit = 10 clocks; tick_in held high must be ignored
      send(6'd19);
      measure(120, trace, rise, high, fall, ready_at, busy_cnt, err_cnt);
      check_eq("int_rise",  rise,     10);
      check_eq("int_high",  high,     30);
      check_eq("int_fall",  fall,     40);
      check_eq("int_ready", ready_at, 70);
`else
      // A with tick every cycle; a different code is offered while busy
      send(6'd0);
      char_code  = 6'd19;
      char_valid = 1'b1;
      measure(40, trace, rise, high, fall, ready_at, busy_cnt, err_cnt);
      char_valid = 1'b0;
      check_eq("a_trace",    trace,    32'h3A);
      check_eq("a_fall",     fall,     6);
      check_eq("a_ready",    ready_at, 9);
      check_eq("a_busy_cnt", busy_cnt, 9);
      check_eq("a_err",      err_cnt,  0);
      cycle();

      // E with tick every 4 cycles
      period  = 4;
      phase   = 0;
      tick_in = 1'b0;
      send(6'd4);
      measure(60, trace, rise, high, fall, ready_at, busy_cnt, err_cnt);
      check_eq("e_rise",       rise,            3);
      check_eq("e_high",       high,            4);
      check_eq("e_fall_ready", ready_at - fall, 12);
      check_eq("e_busy_cnt",   busy_cnt,        19);

      // invalid code
      period = 1;
      cycle();
      send(6'd40);
      check_eq("inv_err",   int'(err_invalid), 1);
      check_eq("inv_key",   int'(key_out),     0);
      check_eq("inv_ready", int'(char_ready),  1);
      check_eq("inv_busy",  int'(busy),        0);
      cycle();
      check_eq("inv_err_pulse", int'(err_invalid), 0);

      // word space
      send(6'd36);
      measure(20, trace, rise, high, fall, ready_at, busy_cnt, err_cnt);
      check_eq("sp_high",     high,     0);
      check_eq("sp_busy_cnt", busy_cnt, 4);
      check_eq("sp_ready",    ready_at, 4);

      // digit 0, reset during the third dash, then S
      send(6'd26);
      for (int i = 0; i < 10; i++) cycle();
      check_eq("d0_key_before_rst", int'(key_out), 1);
      reset_n = 1'b0;
      cycle();
      check_eq("rst_mid_key",   int'(key_out),    0);
      check_eq("rst_mid_ready", int'(char_ready), 1);
      check_eq("rst_mid_busy",  int'(busy),       0);
      reset_n = 1'b1;
      cycle();
      send(6'd18);
      measure(40, trace, rise, high, fall, ready_at, busy_cnt, err_cnt);
      check_eq("s_trace", trace,    32'h2A);
      check_eq("s_ready", ready_at, 9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
